// File: rtl/mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the MEM-stage data-memory access controller:
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - helpers that classify an access as legal and/or misaligned
// ----------------------------------------------------------------------------
package mem_access_unit_pkg;

    // RV32I width/sign codes shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Stores only have B/H/W; loads add the unsigned byte/half variants.
    // Asking for a read and a write at the same time is never legal.
    function automatic logic f3Legal(input logic isRead, input logic isWrite,
                                     input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (isRead && isWrite) begin
            ok = 1'b0;
        end else if (isRead) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end else if (isWrite) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic f3Misaligned(input logic [2:0] f3,
                                          input logic [1:0] addrLo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = addrLo[0];
            F3_W:        mis = (addrLo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// ----------------------------------------------------------------------------
// mem_load_align
// Combinational load-lane extraction and sign/zero extension. Picks the
// addressed byte or halfword out of a 32-bit read word and widens it to
// 32 bits according to the RV32I funct3 code.
//
// Ports:
//   rdata_i    [31:0]  raw word returned by memory
//   addr_lo_i  [1:0]   byte offset of the access inside the word
//   funct3_i   [2:0]   load width/sign code
//   load_val_o [31:0]  aligned, extended load value
// ----------------------------------------------------------------------------
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_val_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    assign byteLane = rdata_i[8*addr_lo_i +: 8];
    assign halfLane = rdata_i[16*addr_lo_i[1] +: 16];

    // Width/sign selection; unknown codes pass the word through untouched
    always_comb begin
        load_val_o = rdata_i;
        case (funct3_i)
            F3_B:    load_val_o = {{24{byteLane[7]}}, byteLane};
            F3_BU:   load_val_o = {24'h000000, byteLane};
            F3_H:    load_val_o = {{16{halfLane[15]}}, halfLane};
            F3_HU:   load_val_o = {16'h0000, halfLane};
            default: load_val_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access controller. Takes the ALU result as the
// effective address, drives a req/ack data bus, builds byte enables and
// lane-replicated store data, and aligns/extends load data for WB. Stalls
// the pipeline while an access is in flight and flags bad accesses/timeouts.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   ex_valid_i           EX/MEM slot holds a valid instruction
//   mem_read_i           load instruction
//   mem_write_i          store instruction
//   funct3_i     [2:0]   RV32I width/sign code
//   alu_result_i [31:0]  effective address
//   store_data_i [31:0]  rs2 value after forwarding
//   dmem_req_o           bus request, held until ack
//   dmem_we_o            1 = write
//   dmem_addr_o  [31:0]  word-aligned address
//   dmem_be_o    [3:0]   byte enables
//   dmem_wdata_o [31:0]  lane-replicated store data
//   dmem_ack_i           bus completion pulse
//   dmem_rdata_i [31:0]  read word, valid with ack
//   load_data_o  [31:0]  aligned, extended load result
//   mem_stall_o          freeze upstream pipeline registers
//   mem_done_o           one-cycle pulse on retire
//   access_exc_o         one-cycle pulse on misaligned/illegal access
//   bus_err_o            one-cycle pulse on bus timeout
// ----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ex_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        mem_stall_o,
    output logic        mem_done_o,
    output logic        access_exc_o,
    output logic        bus_err_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              done_q, done_d;
    logic              exc_q, exc_d;
    logic              berr_q, berr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              is_load_q, is_load_d;

    logic              acc;
    logic              accOk;
    logic [3:0]        beCalc;
    logic [31:0]       wdataCalc;
    logic [31:0]       alignedLoad;

    assign acc   = ex_valid_i && (mem_read_i || mem_write_i);
    assign accOk = acc && f3Legal(mem_read_i, mem_write_i, funct3_i) &&
                   !f3Misaligned(funct3_i, alu_result_i[1:0]);

    // Byte enables and replicated store data for the incoming access.
    // Loads always read the full word; the lane is picked on the way back.
    always_comb begin
        beCalc    = 4'b1111;
        wdataCalc = 32'h0000_0000;
        if (mem_write_i) begin
            case (funct3_i)
                F3_B: begin
                    beCalc    = 4'b0001 << alu_result_i[1:0];
                    wdataCalc = {4{store_data_i[7:0]}};
                end
                F3_H: begin
                    beCalc    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                    wdataCalc = {2{store_data_i[15:0]}};
                end
                default: begin
                    beCalc    = 4'b1111;
                    wdataCalc = store_data_i;
                end
            endcase
        end
    end

    mem_load_align u_load_align (
        .rdata_i    (dmem_rdata_i),
        .addr_lo_i  (addr_lo_q),
        .funct3_i   (funct3_q),
        .load_val_o (alignedLoad)
    );

    // Next-state logic. Bus outputs and load type are captured on accept and
    // then held so the bus sees stable values for the whole transaction;
    // the three status flags default low so they only ever pulse one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        is_load_d   = is_load_q;
        done_d      = 1'b0;
        exc_d       = 1'b0;
        berr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc && !accOk) begin
                    exc_d = 1'b1;
                end else if (accOk) begin
                    addr_d    = {alu_result_i[31:2], 2'b00};
                    be_d      = beCalc;
                    wdata_d   = wdataCalc;
                    we_d      = mem_write_i;
                    funct3_d  = funct3_i;
                    addr_lo_d = alu_result_i[1:0];
                    is_load_d = mem_read_i;
                    req_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Ack is tested first so a late ack on the last allowed
                // cycle still completes the access.
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                    if (is_load_q) begin
                        load_data_d = alignedLoad;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d       = 1'b0;
                    load_data_d = 32'h0000_0000;
                    berr_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            berr_q      <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            berr_q      <= berr_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            is_load_q   <= is_load_d;
        end
    end

    // Stall covers the accept cycle and every BUSY cycle, but drops in DONE
    // so the pipeline advances while the access retires.
    assign mem_stall_o  = ((state_q == IDLE) && accOk) || (state_q == BUSY);

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign load_data_o  = load_data_q;
    assign mem_done_o   = done_q;
    assign access_exc_o = exc_q;
    assign bus_err_o    = berr_q;

endmodule
